alu_2: RTL and testbench

- Small parameterised ALU for the lecture datapath. It selects one of eight operations on two WIDTH-bit operands via a 3-bit opcode.
- Produces a combinational result plus a zero flag on operand A.
- The same result and flag are also captured in a one-cycle output register, so downstream pipeline stages can consume a registered copy.
- Sits between the register file/accumulator and the writeback/branch logic.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_2.sv | 41 ++++
 tb/tb_alu_2.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the lecture-datapath ALU.
package alu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_PASS0 = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_PASS1 = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_AND   = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_PASSB = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_PASS6 = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_PASS7 = 3'd7;

endpackage

// File: rtl/alu_2.sv
// Eight-op ALU with combinational result/zero-flag and a one-cycle registered copy.
module alu_2
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    output logic                a_is_zero,
    output logic [WIDTH-1:0]    alu_out,
    output logic                a_is_zero_q,
    output logic [WIDTH-1:0]    alu_out_q
);

    // Every opcode not explicitly decoded (including X/Z) passes in_a through.
    always_comb begin
        alu_out   = in_a;
        a_is_zero = (in_a == '0);
        case (opcode)
            OP_ADD:   alu_out = in_a + in_b;
            OP_AND:   alu_out = in_a & in_b;
            OP_XOR:   alu_out = in_a ^ in_b;
            OP_PASSB: alu_out = in_b;
            default:  alu_out = in_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q   <= '0;
            a_is_zero_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out;
            a_is_zero_q <= a_is_zero;
        end
    end

endmodule

// File: tb/tb_alu_2.sv
// Directed self-checking bench for alu_2: opcode sweep, zero flag, ADD wrap, registered path and async reset.
module tb_alu_2;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                a_is_zero;
    logic [WIDTH-1:0]    alu_out;
    logic                a_is_zero_q;
    logic [WIDTH-1:0]    alu_out_q;

    int n_cmp = 0;
    int n_bad = 0;

    alu_2 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .a_is_zero   (a_is_zero),
        .alu_out     (alu_out),
        .a_is_zero_q (a_is_zero_q),
        .alu_out_q   (alu_out_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [WIDTH-1:0] sweep_exp [8] = '{8'h42, 8'h42, 8'hC8, 8'h02, 8'hC4, 8'h86, 8'h42, 8'h42};

    initial begin
        rst    = 1'b1;
        opcode = OP_PASS0;
        in_a   = '0;
        in_b   = '0;
        #1;
        chk("rst_out_q", alu_out_q, 0);
        chk("rst_zero_q", a_is_zero_q, 0);

        // Combinational sweep; runs under reset to show rst does not touch it.
        in_a = 8'h42;
        in_b = 8'h86;
        for (int op = 0; op < 8; op++) begin
            opcode = op[OPCODE_W-1:0];
            #1;
            chk($sformatf("sweep_out_op%0d", op), alu_out, sweep_exp[op]);
            chk($sformatf("sweep_zero_op%0d", op), a_is_zero, 0);
        end

        opcode = OP_PASS7; in_a = 8'h00; in_b = 8'h86; #1;
        chk("pass7_a0_out", alu_out, 8'h00);
        chk("pass7_a0_zero", a_is_zero, 1);

        opcode = OP_PASSB; #1;
        chk("passb_a0_out", alu_out, 8'h86);
        chk("passb_a0_zero", a_is_zero, 1);

        opcode = OP_ADD; in_a = 8'hFF; in_b = 8'h01; #1;
        chk("add_wrap_out", alu_out, 8'h00);
        chk("add_wrap_zero", a_is_zero, 0);

        // Registers must hold zero across edges while rst is high.
        @(posedge clk); #1;
        chk("rst_hold_out_q", alu_out_q, 0);
        chk("rst_hold_zero_q", a_is_zero_q, 0);

        @(negedge clk);
        rst = 1'b0;
        opcode = OP_ADD; in_a = 8'h42; in_b = 8'h86;
        #1;
        chk("no_edge_yet_out_q", alu_out_q, 0);
        @(posedge clk); #1;
        chk("reg_add_out_q", alu_out_q, 8'hC8);
        chk("reg_add_zero_q", a_is_zero_q, 0);

        @(negedge clk);
        in_a = 8'h00;
        #1;
        chk("reg_pre_zero_q", a_is_zero_q, 0);
        @(posedge clk); #1;
        chk("reg_a0_zero_q", a_is_zero_q, 1);
        chk("reg_a0_out_q", alu_out_q, 8'h86);

        // Async assert between edges clears the flag without a clock.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_zero_q", a_is_zero_q, 0);
        chk("async_out_q", alu_out_q, 0);
        #1 rst = 1'b0;

        @(negedge clk);
        in_a = 8'h42;
        @(posedge clk); #1;
        chk("recap_out_q", alu_out_q, 8'hC8);

        // Mid-stream pulse: registered value discarded, comb output keeps tracking.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_q", alu_out_q, 0);
        chk("mid_rst_alu_out", alu_out, 8'hC8);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_hold_q", alu_out_q, 0);
        chk("post_rst_alu_out", alu_out, 8'hC8);
        @(posedge clk); #1;
        chk("post_rst_cap_q", alu_out_q, 8'hC8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
